// File: rtl/glb_fifo_arbiter_if.sv
// Bundle of FIFO-side request/permit signals and the GLB SRAM port shared by
// the arbiter (slave) and the channel FIFOs / GLB model (master).
interface glb_fifo_arbiter_if #(
    parameter int NUM_CH = 32
);
    logic [NUM_CH-1:0]            ifmap_read_req_matrix_i;
    logic [NUM_CH-1:0][31:0]      ifmap_glb_read_addr_matrix_i;
    logic [NUM_CH-1:0]            ipsum_read_req_matrix_i;
    logic [NUM_CH-1:0][31:0]      ipsum_glb_read_addr_matrix_i;
    logic [NUM_CH-1:0]            opsum_glb_write_req_matrix_i;
    logic [NUM_CH-1:0][31:0]      opsum_glb_write_addr_matrix_i;
    logic [NUM_CH-1:0][3:0]       opsum_glb_write_web_matrix_i;
    logic [NUM_CH-1:0][31:0]      opsum_fifo_head_data_matrix_i;
    logic [NUM_CH-1:0]            ifmap_permit_push_matrix_o;
    logic [NUM_CH-1:0]            ipsum_permit_push_matrix_o;
    logic [NUM_CH-1:0]            opsum_permit_pop_matrix_o;
    logic [31:0]                  ifmap_glb_read_data_o;
    logic [31:0]                  ipsum_glb_read_data_o;
    logic                         fifo_glb_busy_o;
    logic                         glb_ce_o;
    logic [31:0]                  glb_addr_o;
    logic [3:0]                   glb_web_o;
    logic [31:0]                  glb_wdata_o;
    logic [31:0]                  glb_rdata_i;

    modport slave (
        input  ifmap_read_req_matrix_i, ifmap_glb_read_addr_matrix_i,
        input  ipsum_read_req_matrix_i, ipsum_glb_read_addr_matrix_i,
        input  opsum_glb_write_req_matrix_i, opsum_glb_write_addr_matrix_i,
        input  opsum_glb_write_web_matrix_i, opsum_fifo_head_data_matrix_i,
        input  glb_rdata_i,
        output ifmap_permit_push_matrix_o, ipsum_permit_push_matrix_o,
        output opsum_permit_pop_matrix_o,
        output ifmap_glb_read_data_o, ipsum_glb_read_data_o,
        output fifo_glb_busy_o, glb_ce_o, glb_addr_o, glb_web_o, glb_wdata_o
    );

    modport master (
        output ifmap_read_req_matrix_i, ifmap_glb_read_addr_matrix_i,
        output ipsum_read_req_matrix_i, ipsum_glb_read_addr_matrix_i,
        output opsum_glb_write_req_matrix_i, opsum_glb_write_addr_matrix_i,
        output opsum_glb_write_web_matrix_i, opsum_fifo_head_data_matrix_i,
        output glb_rdata_i,
        input  ifmap_permit_push_matrix_o, ipsum_permit_push_matrix_o,
        input  opsum_permit_pop_matrix_o,
        input  ifmap_glb_read_data_o, ipsum_glb_read_data_o,
        input  fifo_glb_busy_o, glb_ce_o, glb_addr_o, glb_web_o, glb_wdata_o
    );
endinterface

// File: rtl/glb_fifo_arbiter.sv
// Single-port GLB arbiter for the ifmap/ipsum read FIFOs and the opsum write
// FIFOs. Fixed class priority (opsum > ifmap > ipsum), round-robin within a
// class, one GLB transaction in flight at a time.
module glb_fifo_arbiter #(
    parameter int NUM_CH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    glb_fifo_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic [1:0] {CLS_OPSUM, CLS_IFMAP, CLS_IPSUM} cls_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // First asserted request at or above ptr, wrapping past NUM_CH-1.
    function automatic ptr_t rr_pick(input logic [NUM_CH-1:0] req, input ptr_t ptr);
        ptr_t pick = ptr;
        ptr_t cand;
        logic hit = 1'b0;
        int   j;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) j -= NUM_CH;
            cand = ptr_t'(j);
            if (!hit && req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
        return pick;
    endfunction

    // Pointer moves just past the winner, modulo NUM_CH.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NUM_CH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    ptr_t        idx_q, idx_d;
    ptr_t        ptr_op_q, ptr_op_d;
    ptr_t        ptr_if_q, ptr_if_d;
    ptr_t        ptr_ip_q, ptr_ip_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  web_q, web_d;
    logic [31:0] data_q, data_d;
    ptr_t        win;

    logic [NUM_CH-1:0] pop, if_push, ip_push;
    logic [31:0]       if_rdata, ip_rdata, glb_addr, glb_wdata;
    logic [3:0]        glb_web;
    logic              glb_ce;

    // Control state: FSM, granted class/index and round-robin pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cls_q    <= CLS_OPSUM;
            idx_q    <= '0;
            ptr_op_q <= '0;
            ptr_if_q <= '0;
            ptr_ip_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            idx_q    <= idx_d;
            ptr_op_q <= ptr_op_d;
            ptr_if_q <= ptr_if_d;
            ptr_ip_q <= ptr_ip_d;
        end
    end

    // Transaction payload, captured only at grant; outputs are gated by state.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        web_q  <= web_d;
        data_q <= data_d;
    end

    // Grant decision in IDLE, GLB access/pulses in ACCESS and RESP.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        idx_d     = idx_q;
        ptr_op_d  = ptr_op_q;
        ptr_if_d  = ptr_if_q;
        ptr_ip_d  = ptr_ip_q;
        addr_d    = addr_q;
        web_d     = web_q;
        data_d    = data_q;
        win       = '0;
        pop       = '0;
        if_push   = '0;
        ip_push   = '0;
        if_rdata  = '0;
        ip_rdata  = '0;
        glb_ce    = 1'b0;
        glb_addr  = '0;
        glb_web   = 4'hF;
        glb_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.opsum_glb_write_req_matrix_i) begin
                    win      = rr_pick(bus.opsum_glb_write_req_matrix_i, ptr_op_q);
                    cls_d    = CLS_OPSUM;
                    idx_d    = win;
                    addr_d   = bus.opsum_glb_write_addr_matrix_i[win];
                    web_d    = bus.opsum_glb_write_web_matrix_i[win];
                    data_d   = bus.opsum_fifo_head_data_matrix_i[win];
                    ptr_op_d = ptr_inc(win);
                    state_d  = ST_ACCESS;
                end else if (|bus.ifmap_read_req_matrix_i) begin
                    win      = rr_pick(bus.ifmap_read_req_matrix_i, ptr_if_q);
                    cls_d    = CLS_IFMAP;
                    idx_d    = win;
                    addr_d   = bus.ifmap_glb_read_addr_matrix_i[win];
                    web_d    = 4'hF;
                    ptr_if_d = ptr_inc(win);
                    state_d  = ST_ACCESS;
                end else if (|bus.ipsum_read_req_matrix_i) begin
                    win      = rr_pick(bus.ipsum_read_req_matrix_i, ptr_ip_q);
                    cls_d    = CLS_IPSUM;
                    idx_d    = win;
                    addr_d   = bus.ipsum_glb_read_addr_matrix_i[win];
                    web_d    = 4'hF;
                    ptr_ip_d = ptr_inc(win);
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                glb_ce   = 1'b1;
                glb_addr = addr_q;
                if (cls_q == CLS_OPSUM) begin
                    // Writes finish in one cycle: pop the head as it is written.
                    glb_web     = web_q;
                    glb_wdata   = data_q;
                    pop[idx_q]  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cls_q == CLS_IFMAP) begin
                    if_push[idx_q] = 1'b1;
                    if_rdata       = bus.glb_rdata_i;
                end else if (cls_q == CLS_IPSUM) begin
                    ip_push[idx_q] = 1'b1;
                    ip_rdata       = bus.glb_rdata_i;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.opsum_permit_pop_matrix_o  = pop;
    assign bus.ifmap_permit_push_matrix_o = if_push;
    assign bus.ipsum_permit_push_matrix_o = ip_push;
    assign bus.ifmap_glb_read_data_o      = if_rdata;
    assign bus.ipsum_glb_read_data_o      = ip_rdata;
    assign bus.glb_ce_o                   = glb_ce;
    assign bus.glb_addr_o                 = glb_addr;
    assign bus.glb_web_o                  = glb_web;
    assign bus.glb_wdata_o                = glb_wdata;
    assign bus.fifo_glb_busy_o            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_glb_fifo_arbiter.sv
// Bench for glb_fifo_arbiter: transaction-level model with a per-cycle
// compare process, plus directed scenarios with literal expectations.
module tb_glb_fifo_arbiter;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    glb_fifo_arbiter_if #(.NUM_CH(N)) bus ();
    glb_fifo_arbiter #(.NUM_CH(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs for one cycle.
    typedef struct {
        logic        busy;
        logic        ce;
        logic [31:0] addr;
        logic [3:0]  web;
        logic [31:0] wdata;
        logic [31:0] pop;
        logic [31:0] ifp;
        logic [31:0] ipp;
        logic        echo_if;
        logic        echo_ip;
    } exp_t;

    exp_t       mq[$];
    logic [4:0] mptr[3];

    function automatic exp_t idle_rec();
        exp_t r;
        r.busy = 1'b0; r.ce = 1'b0; r.addr = '0; r.web = 4'hF; r.wdata = '0;
        r.pop = '0; r.ifp = '0; r.ipp = '0; r.echo_if = 1'b0; r.echo_ip = 1'b0;
        return r;
    endfunction

    // Rotate the request vector so the pointer sits at bit 0; lowest set bit wins.
    function automatic int rr(input logic [31:0] req, input int p);
        logic [31:0] rot = (req >> p) | (req << (N - p));
        for (int k = 0; k < N; k++)
            if ((rot & (32'd1 << k)) != 0) return (p + k) % N;
        return p;
    endfunction

    // Queue up the cycles a new grant will produce.
    task automatic decide();
        exp_t       a, r;
        logic [4:0] w;
        a = idle_rec(); a.busy = 1'b1; a.ce = 1'b1;
        r = idle_rec(); r.busy = 1'b1;
        if (bus.opsum_glb_write_req_matrix_i != 0) begin
            w = 5'(rr(bus.opsum_glb_write_req_matrix_i, int'(mptr[0])));
            mptr[0] = w + 5'd1;
            a.addr  = bus.opsum_glb_write_addr_matrix_i[w];
            a.web   = bus.opsum_glb_write_web_matrix_i[w];
            a.wdata = bus.opsum_fifo_head_data_matrix_i[w];
            a.pop   = 32'd1 << w;
            mq.push_back(a);
        end else if (bus.ifmap_read_req_matrix_i != 0) begin
            w = 5'(rr(bus.ifmap_read_req_matrix_i, int'(mptr[1])));
            mptr[1] = w + 5'd1;
            a.addr  = bus.ifmap_glb_read_addr_matrix_i[w];
            r.ifp   = 32'd1 << w;
            r.echo_if = 1'b1;
            mq.push_back(a);
            mq.push_back(r);
        end else if (bus.ipsum_read_req_matrix_i != 0) begin
            w = 5'(rr(bus.ipsum_read_req_matrix_i, int'(mptr[2])));
            mptr[2] = w + 5'd1;
            a.addr  = bus.ipsum_glb_read_addr_matrix_i[w];
            r.ipp   = 32'd1 << w;
            r.echo_ip = 1'b1;
            mq.push_back(a);
            mq.push_back(r);
        end
    endtask

    // Model compare on every negative edge, away from the sampling edge.
    always @(negedge clk) begin : model
        exp_t e;
        if (!rst_n) begin
            mq.delete();
            mptr[0] = '0; mptr[1] = '0; mptr[2] = '0;
            e = idle_rec();
        end else if (mq.size() == 0) begin
            e = idle_rec();
            decide();
        end else begin
            e = mq.pop_front();
        end
        chk("m_busy",  32'(bus.fifo_glb_busy_o), 32'(e.busy));
        chk("m_ce",    32'(bus.glb_ce_o), 32'(e.ce));
        chk("m_addr",  bus.glb_addr_o, e.addr);
        chk("m_web",   32'(bus.glb_web_o), 32'(e.web));
        chk("m_wdata", bus.glb_wdata_o, e.wdata);
        chk("m_pop",   bus.opsum_permit_pop_matrix_o, e.pop);
        chk("m_ifp",   bus.ifmap_permit_push_matrix_o, e.ifp);
        chk("m_ipp",   bus.ipsum_permit_push_matrix_o, e.ipp);
        chk("m_ifd",   bus.ifmap_glb_read_data_o, e.echo_if ? bus.glb_rdata_i : 32'h0);
        chk("m_ipd",   bus.ipsum_glb_read_data_o, e.echo_ip ? bus.glb_rdata_i : 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(bus.fifo_glb_busy_o), 32'h0);
        chk({nm, "_ce"},   32'(bus.glb_ce_o), 32'h0);
        chk({nm, "_web"},  32'(bus.glb_web_o), 32'hF);
        chk({nm, "_addr"}, bus.glb_addr_o, 32'h0);
        chk({nm, "_wd"},   bus.glb_wdata_o, 32'h0);
        chk({nm, "_ifp"},  bus.ifmap_permit_push_matrix_o, 32'h0);
        chk({nm, "_ifd"},  bus.ifmap_glb_read_data_o, 32'h0);
    endtask

    logic [31:0] pat_op[6] = '{32'h0, 32'h0000_0006, 32'h0, 32'h8000_0001, 32'h0, 32'h0};
    logic [31:0] pat_if[6] = '{32'h8000_0011, 32'h0, 32'h0, 32'h0000_FFFF, 32'h5555_5555, 32'h0};
    logic [31:0] pat_ip[6] = '{32'h0000_0100, 32'hF000_0000, 32'h0000_0081, 32'h1, 32'h0, 32'h0};

    initial begin : stim
        rst_n = 1'b0;
        bus.ifmap_read_req_matrix_i      = '0;
        bus.ipsum_read_req_matrix_i      = '0;
        bus.opsum_glb_write_req_matrix_i = '0;
        bus.glb_rdata_i                  = 32'h1234_5678;
        for (int i = 0; i < N; i++) begin
            bus.ifmap_glb_read_addr_matrix_i[5'(i)]  = 32'h1000 + 32'(4 * i);
            bus.ipsum_glb_read_addr_matrix_i[5'(i)]  = 32'h2000 + 32'(4 * i);
            bus.opsum_glb_write_addr_matrix_i[5'(i)] = 32'h3000 + 32'(4 * i);
            bus.opsum_glb_write_web_matrix_i[5'(i)]  = 4'(i);
            bus.opsum_fifo_head_data_matrix_i[5'(i)] = 32'hC0DE_0000 + 32'(i);
        end
        repeat (3) mid();
        chk_reset_vals("rst0");
        tick(); rst_n = 1'b1;
        mid();

        // Single ifmap read on channel 5.
        tick();
        bus.ifmap_glb_read_addr_matrix_i[5] = 32'h100;
        bus.ifmap_read_req_matrix_i[5] = 1'b1;
        mid(); chk("r020_t_busy", 32'(bus.fifo_glb_busy_o), 32'h0);
        tick();
        bus.ifmap_read_req_matrix_i[5] = 1'b0;
        bus.ifmap_glb_read_addr_matrix_i[5] = 32'hFFFF_0000;
        mid();
        chk("r020_ce", 32'(bus.glb_ce_o), 32'h1);
        chk("r020_addr", bus.glb_addr_o, 32'h100);
        chk("r020_web", 32'(bus.glb_web_o), 32'hF);
        chk("r020_busy1", 32'(bus.fifo_glb_busy_o), 32'h1);
        tick(); bus.glb_rdata_i = 32'hA5A5_0001;
        mid();
        chk("r020_push", bus.ifmap_permit_push_matrix_o, 32'h0000_0020);
        chk("r020_data", bus.ifmap_glb_read_data_o, 32'hA5A5_0001);
        chk("r020_busy2", 32'(bus.fifo_glb_busy_o), 32'h1);
        tick(); bus.glb_rdata_i = 32'h1234_5678;
        mid();
        chk("r020_after_busy", 32'(bus.fifo_glb_busy_o), 32'h0);
        chk("r020_after_data", bus.ifmap_glb_read_data_o, 32'h0);

        // Single opsum write on channel 3.
        tick();
        bus.opsum_glb_write_addr_matrix_i[3] = 32'h40;
        bus.opsum_glb_write_web_matrix_i[3]  = 4'h0;
        bus.opsum_fifo_head_data_matrix_i[3] = 32'hDEAD_BEEF;
        bus.opsum_glb_write_req_matrix_i[3]  = 1'b1;
        mid();
        tick();
        bus.opsum_glb_write_req_matrix_i[3]  = 1'b0;
        bus.opsum_fifo_head_data_matrix_i[3] = 32'h0;
        mid();
        chk("r021_ce", 32'(bus.glb_ce_o), 32'h1);
        chk("r021_web", 32'(bus.glb_web_o), 32'h0);
        chk("r021_wdata", bus.glb_wdata_o, 32'hDEAD_BEEF);
        chk("r021_addr", bus.glb_addr_o, 32'h40);
        chk("r021_pop", bus.opsum_permit_pop_matrix_o, 32'h0000_0008);
        tick(); mid();
        chk("r021_busy2", 32'(bus.fifo_glb_busy_o), 32'h0);

        // Class priority: all three classes request channel 0 together.
        tick();
        bus.opsum_glb_write_req_matrix_i[0] = 1'b1;
        bus.ifmap_read_req_matrix_i[0]      = 1'b1;
        bus.ipsum_read_req_matrix_i[0]      = 1'b1;
        mid();
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            if (cyc == 1) bus.opsum_glb_write_req_matrix_i[0] = 1'b0;
            if (cyc == 3) bus.ifmap_read_req_matrix_i[0] = 1'b0;
            if (cyc == 6) bus.ipsum_read_req_matrix_i[0] = 1'b0;
            mid();
            if (cyc == 1) chk("r022_pop", bus.opsum_permit_pop_matrix_o, 32'h1);
            if (cyc == 4) chk("r022_ifp", bus.ifmap_permit_push_matrix_o, 32'h1);
            if (cyc == 7) chk("r022_ipp", bus.ipsum_permit_push_matrix_o, 32'h1);
        end

        // Reset while idle brings all pointers back to 0.
        tick(); rst_n = 1'b0;
        mid(); chk_reset_vals("rst1");
        tick(); rst_n = 1'b1;
        mid();

        // Round-robin wrap over ifmap channels 31, 0, 2.
        tick();
        bus.ifmap_read_req_matrix_i = 32'h8000_0005;
        mid();
        for (int cyc = 1; cyc <= 11; cyc++) begin
            tick();
            if (cyc == 10) bus.ifmap_read_req_matrix_i = '0;
            mid();
            if (cyc == 2)  chk("r023_g0", bus.ifmap_permit_push_matrix_o, 32'h0000_0001);
            if (cyc == 5)  chk("r023_g1", bus.ifmap_permit_push_matrix_o, 32'h0000_0004);
            if (cyc == 8)  chk("r023_g2", bus.ifmap_permit_push_matrix_o, 32'h8000_0000);
            if (cyc == 11) chk("r023_g3", bus.ifmap_permit_push_matrix_o, 32'h0000_0001);
        end

        // Reset during RESP aborts the read; the held request is re-granted.
        tick(); bus.ifmap_read_req_matrix_i[7] = 1'b1;
        mid();
        tick(); mid();
        chk("r024_acc_addr", bus.glb_addr_o, 32'h101C);
        tick();
        bus.glb_rdata_i = 32'h7777_0007;
        rst_n = 1'b0;
        #1;
        chk("r024_async_busy", 32'(bus.fifo_glb_busy_o), 32'h0);
        mid(); chk_reset_vals("r024_rst");
        tick(); rst_n = 1'b1;
        mid(); chk("r024_idle_busy", 32'(bus.fifo_glb_busy_o), 32'h0);
        tick(); bus.ifmap_read_req_matrix_i[7] = 1'b0;
        mid();
        chk("r024_re_ce", 32'(bus.glb_ce_o), 32'h1);
        chk("r024_re_addr", bus.glb_addr_o, 32'h101C);
        tick(); mid();
        chk("r024_re_push", bus.ifmap_permit_push_matrix_o, 32'h0000_0080);
        chk("r024_re_data", bus.ifmap_glb_read_data_o, 32'h7777_0007);

        // Mixed-class load, checked by the model every cycle.
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 12; c++) begin
                tick();
                bus.opsum_glb_write_req_matrix_i = pat_op[p];
                bus.ifmap_read_req_matrix_i      = pat_if[p];
                bus.ipsum_read_req_matrix_i      = pat_ip[p];
                bus.glb_rdata_i                  = 32'h5A00_0000 + 32'(p * 16 + c);
                mid();
            end
        end
        repeat (4) begin tick(); mid(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/glb_fifo_arbiter.md
GLB_FIFO_ARBITER -- requirements
Module: glb_fifo_arbiter

Interface
REQ-001 Parameter NUM_CH, default 32, meaning the number of FIFO channels per class (ifmap, ipsum, opsum).
REQ-002 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ifmap_read_req_matrix_i  in  NUM_CH  per-channel GLB read request
- ifmap_glb_read_addr_matrix_i  in  32 x NUM_CH  read addresses
- ipsum_read_req_matrix_i  in  NUM_CH  per-channel GLB read request
- ipsum_glb_read_addr_matrix_i  in  32 x NUM_CH  read addresses
- opsum_glb_write_req_matrix_i  in  NUM_CH  per-channel GLB write request
- opsum_glb_write_addr_matrix_i  in  32 x NUM_CH  write addresses
- opsum_glb_write_web_matrix_i  in  4 x NUM_CH  byte write-enable-bar (0 = write byte)
- opsum_fifo_head_data_matrix_i  in  32 x NUM_CH  opsum FIFO head word
- ifmap_permit_push_matrix_o  out  NUM_CH  one-hot pulse: read data valid, push it
- ipsum_permit_push_matrix_o  out  NUM_CH  one-hot pulse: read data valid, push it
- opsum_permit_pop_matrix_o  out  NUM_CH  one-hot pulse: head written, pop it
- ifmap_glb_read_data_o  out  32  returned read word for ifmap
- ipsum_glb_read_data_o  out  32  returned read word for ipsum
- fifo_glb_busy_o  out  1  transaction in flight
- glb_ce_o  out  1  GLB access enable
- glb_addr_o  out  32  GLB address
- glb_web_o  out  4  GLB byte write-enable-bar; 4'hF = read
- glb_wdata_o  out  32  GLB write data
- glb_rdata_i  in  32  GLB read data, valid 1 cycle after a read access

Function
REQ-004 FSM states: IDLE, ACCESS, RESP; at most one GLB transaction in flight.
REQ-005 IDLE: if any request is asserted, select exactly one winner, latch class, index, address, web, and data, and go to ACCESS; otherwise stay in IDLE.
REQ-006 Class priority is fixed: opsum > ifmap > ipsum.
REQ-007 Within a class, arbitration is round-robin: the winner is the first asserted index at or above that class's pointer, wrapping NUM_CH-1 to 0.
REQ-008 After a grant, the winning class pointer becomes (winner+1) mod NUM_CH; the other class pointers are unchanged.
REQ-009 ACCESS (one cycle): glb_ce_o=1 and glb_addr_o=latched address.
- Read: glb_web_o=4'hF; next state RESP.
- Write: glb_web_o=latched web, glb_wdata_o=latched data, opsum_permit_pop_matrix_o[winner]=1 this cycle; next state IDLE.
REQ-010 RESP (one cycle): the winning class permit_push[winner]=1 and that class read_data_o=glb_rdata_i; next state IDLE.
REQ-011 Latency, request seen in IDLE at cycle T:
- Write: GLB write and pop pulse at T+1; next grant decision at T+2.
- Read: GLB access at T+1; data and push pulse at T+2; next grant decision at T+3.
REQ-012 Outside their pulse cycle, all permit outputs SHALL be 0, both read_data outputs SHALL be 0, glb_ce_o=0, and glb_web_o=4'hF.
REQ-013 fifo_glb_busy_o=1 whenever state is not IDLE.
REQ-014 A grant, once latched, completes even if its request deasserts. Requests arriving while not IDLE are not sampled until IDLE.
REQ-015 At most one bit across all three permit vectors is high in any cycle.
REQ-016 A request held high continuously is granted within 2*NUM_CH+1 decisions, provided no higher class is continuously requesting. Lower-class starvation under persistent higher-class load is accepted behaviour.
REQ-017 Address, web, and data are sampled only in the IDLE grant cycle; later input changes do not affect the in-flight transaction.

Reset
REQ-018 On rst_n=0 the block SHALL immediately, asynchronously, enter IDLE with all round-robin pointers 0, all permits 0, read data outputs 0, glb_ce_o=0, glb_addr_o=0, glb_wdata_o=0, glb_web_o=4'hF, and fifo_glb_busy_o=0.
REQ-019 Reset asserted mid-transaction aborts it: no permit pulse is issued, and the request is re-arbitrated from IDLE after reset release.

Verification
REQ-020 Single read: ifmap_read_req[5]=1, addr 0x100, glb_rdata_i=0xA5A5_0001 at T+2 -> glb_ce_o=1, glb_addr_o=0x100, glb_web_o=4'hF at T+1; ifmap_permit_push[5]=1 and ifmap_glb_read_data_o=0xA5A5_0001 at T+2; busy high at T+1 and T+2.
REQ-021 Single write: opsum_write_req[3]=1, addr 0x40, web 4'h0, head data 0xDEAD_BEEF -> at T+1: glb_ce_o=1, glb_web_o=4'h0, glb_wdata_o=0xDEAD_BEEF, opsum_permit_pop[3]=1; busy low at T+2.
REQ-022 Priority: opsum[0], ifmap[0], and ipsum[0] requested simultaneously and held -> grant order opsum, ifmap, ipsum, with the opsum request dropped after its pop.
REQ-023 Round-robin with wrap: ifmap_read_req bits 31, 0, and 2 held, pointer 0 -> grant order 0, 2, 31, 0.
REQ-024 Reset mid-read: rst_n=0 during RESP -> all outputs take reset values in the same cycle; no permit pulse; after release, the held request is granted again from IDLE.
